// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite master: turns a command/response handshake into
// AXI4-Lite read and write transactions. All AXI outputs are registered.
module axi_lite_master #(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 32
) (
  input  logic                              M_AXI_ACLK,
  input  logic                              M_AXI_ARESET,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic                              rsp_write,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                        rsp_resp,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                        M_AXI_AWPROT,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                        M_AXI_ARPROT,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY
);

  localparam int SW = C_M_AXI_DATA_WIDTH / 8;

  typedef enum logic [2:0] {IDLE, WR, WB, RA, RD, RSP} state_t;

  state_t                        state, state_n;
  logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q, addr_n;
  logic [C_M_AXI_DATA_WIDTH-1:0] wdata_n, rsp_rdata_n;
  logic [SW-1:0]                 wstrb_n;
  logic [1:0]                    rsp_resp_n;
  logic                          aw_done, w_done, aw_done_n, w_done_n;
  logic                          awvalid_n, wvalid_n, bready_n, arvalid_n, rready_n;
  logic                          rsp_valid_n, rsp_write_n;
  logic                          accept, aw_hs, w_hs, aw_all, w_all;

  assign cmd_ready    = (state == IDLE);
  assign accept       = cmd_valid && cmd_ready;
  assign aw_hs        = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_hs         = M_AXI_WVALID && M_AXI_WREADY;
  // A handshake in the current cycle counts as done for the WR->WB decision.
  assign aw_all       = aw_done || aw_hs;
  assign w_all        = w_done || w_hs;
  assign M_AXI_AWADDR = addr_q;
  assign M_AXI_ARADDR = addr_q;
  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      state         <= IDLE;
      addr_q        <= '0;
      M_AXI_WDATA   <= '0;
      M_AXI_WSTRB   <= '0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_write     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= '0;
    end else begin
      state         <= state_n;
      addr_q        <= addr_n;
      M_AXI_WDATA   <= wdata_n;
      M_AXI_WSTRB   <= wstrb_n;
      aw_done       <= aw_done_n;
      w_done        <= w_done_n;
      M_AXI_AWVALID <= awvalid_n;
      M_AXI_WVALID  <= wvalid_n;
      M_AXI_BREADY  <= bready_n;
      M_AXI_ARVALID <= arvalid_n;
      M_AXI_RREADY  <= rready_n;
      rsp_valid     <= rsp_valid_n;
      rsp_write     <= rsp_write_n;
      rsp_rdata     <= rsp_rdata_n;
      rsp_resp      <= rsp_resp_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = cmd_write ? WR : RA;
      WR:      if (aw_all && w_all) state_n = WB;
      WB:      if (M_AXI_BVALID) state_n = RSP;
      RA:      if (M_AXI_ARVALID && M_AXI_ARREADY) state_n = RD;
      RD:      if (M_AXI_RVALID) state_n = RSP;
      RSP:     if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Next values for the registered outputs; everything holds unless a case updates it.
  always_comb begin
    addr_n      = addr_q;
    wdata_n     = M_AXI_WDATA;
    wstrb_n     = M_AXI_WSTRB;
    aw_done_n   = aw_done;
    w_done_n    = w_done;
    awvalid_n   = M_AXI_AWVALID;
    wvalid_n    = M_AXI_WVALID;
    bready_n    = M_AXI_BREADY;
    arvalid_n   = M_AXI_ARVALID;
    rready_n    = M_AXI_RREADY;
    rsp_valid_n = rsp_valid;
    rsp_write_n = rsp_write;
    rsp_rdata_n = rsp_rdata;
    rsp_resp_n  = rsp_resp;
    case (state)
      IDLE: if (accept) begin
        addr_n  = cmd_addr;
        wdata_n = cmd_wdata;
        wstrb_n = cmd_wstrb;
        if (cmd_write) begin
          awvalid_n = 1'b1;
          wvalid_n  = 1'b1;
          aw_done_n = 1'b0;
          w_done_n  = 1'b0;
        end else begin
          arvalid_n = 1'b1;
        end
      end
      WR: begin
        if (aw_hs) begin
          awvalid_n = 1'b0;
          aw_done_n = 1'b1;
        end
        if (w_hs) begin
          wvalid_n = 1'b0;
          w_done_n = 1'b1;
        end
        if (aw_all && w_all) bready_n = 1'b1;
      end
      WB: if (M_AXI_BVALID) begin
        bready_n    = 1'b0;
        rsp_valid_n = 1'b1;
        rsp_write_n = 1'b1;
        rsp_rdata_n = '0;
        rsp_resp_n  = M_AXI_BRESP;
      end
      RA: if (M_AXI_ARVALID && M_AXI_ARREADY) begin
        arvalid_n = 1'b0;
        rready_n  = 1'b1;
      end
      RD: if (M_AXI_RVALID) begin
        rready_n    = 1'b0;
        rsp_valid_n = 1'b1;
        rsp_write_n = 1'b0;
        rsp_rdata_n = M_AXI_RDATA;
        rsp_resp_n  = M_AXI_RRESP;
      end
      RSP: if (rsp_ready) rsp_valid_n = 1'b0;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: reactive AXI4-Lite slave with a 16-word memory,
// a memory-level reference model feeding a response scoreboard, and cycle traces.
module tb_axi_lite_master;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = DW / 8;
  localparam int TRN = 16384;

  logic          clk, rst;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_wstrb;
  logic          rsp_valid, rsp_ready, rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [SW-1:0] wstrb;
  logic [1:0]    bresp, rresp;

  axi_lite_master #(.C_M_AXI_DATA_WIDTH(DW), .C_M_AXI_ADDR_WIDTH(AW)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: word memory plus address-decoded response code.
  typedef struct { logic w; logic [DW-1:0] d; logic [1:0] r; } exp_t;
  exp_t          expq[$];
  logic [AW-1:0] addrq[$];
  logic [DW-1:0] ref_mem [16];
  logic [DW-1:0] s_mem [16];

  function automatic logic [1:0] resp_of(input logic [AW-1:0] a);
    case (a[7:6])
      2'b10:   return 2'b10;
      2'b11:   return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  // Slave configuration, driven by the main sequence.
  bit rnd = 0, spur_en = 0, spur_done = 0;
  int aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
  int rsp_hold = 0;
  bit rsp_rnd = 0;
  int last_hs = -1;

  bit tr_awv [TRN], tr_wv [TRN], tr_bready [TRN], tr_arv [TRN], tr_rready [TRN], tr_rspv [TRN];

  // Reactive slave: handshakes are observed at negedge, drives change 1 time unit after posedge.
  initial begin
    bit have_aw, have_w, b_pend, r_pend, spur_on, rst_s, aw_h, w_h, b_h, ar_h, r_h;
    int b_cnt, r_cnt, aw_cnt, w_cnt, ar_cnt;
    logic [AW-1:0] s_awaddr, s_araddr;
    logic [DW-1:0] s_wdata;
    logic [SW-1:0] s_wstrb;
    logic [1:0]    b_resp;
    have_aw = 0; have_w = 0; b_pend = 0; r_pend = 0; spur_on = 0;
    b_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_resp = '0;
    s_awaddr = '0; s_araddr = '0; s_wdata = '0; s_wstrb = '0;
    awready = 0; wready = 0; bvalid = 0; bresp = '0; arready = 0; rvalid = 0; rresp = '0; rdata = '0;
    for (int i = 0; i < 16; i++) s_mem[i] = '0;
    forever begin
      @(negedge clk);
      rst_s = rst;
      aw_h = awvalid && awready;
      w_h  = wvalid && wready;
      b_h  = bvalid && bready;
      ar_h = arvalid && arready;
      r_h  = rvalid && rready;
      if (spur_on) chk("bready_during_wr", bready, 0);
      if (aw_h) begin
        s_awaddr = awaddr;
        if (addrq.size() == 0) chk("awaddr_unexpected", 1, 0);
        else chk("awaddr", awaddr, addrq.pop_front());
      end
      if (w_h) begin
        s_wdata = wdata;
        s_wstrb = wstrb;
      end
      if (ar_h) begin
        s_araddr = araddr;
        if (addrq.size() == 0) chk("araddr_unexpected", 1, 0);
        else chk("araddr", araddr, addrq.pop_front());
      end
      @(posedge clk);
      #1;
      if (rst_s) begin
        have_aw = 0; have_w = 0; b_pend = 0; r_pend = 0; spur_on = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
        continue;
      end
      if (aw_h) have_aw = 1;
      if (w_h) have_w = 1;
      if (b_h) begin bvalid = 0; bresp = 2'($urandom); end
      if (spur_on) begin bvalid = 0; spur_on = 0; bresp = 2'($urandom); end
      if (have_aw && have_w) begin
        for (int b = 0; b < SW; b++)
          if (s_wstrb[b]) s_mem[s_awaddr[5:2]][8*b +: 8] = s_wdata[8*b +: 8];
        have_aw = 0; have_w = 0; b_pend = 1;
        b_cnt  = rnd ? int'($urandom_range(0, 3)) : b_dly;
        b_resp = resp_of(s_awaddr);
      end
      if (b_pend) begin
        if (b_cnt == 0) begin bvalid = 1; bresp = b_resp; b_pend = 0; end
        else b_cnt--;
      end else if (spur_en && !spur_done && !bvalid && (awvalid || wvalid)) begin
        bvalid = 1; bresp = 2'b11; spur_on = 1; spur_done = 1;
      end
      if (r_h) begin rvalid = 0; rdata = $urandom; rresp = 2'($urandom); end
      if (ar_h) begin
        r_pend = 1;
        r_cnt  = rnd ? int'($urandom_range(0, 3)) : r_dly;
      end
      if (r_pend) begin
        if (r_cnt == 0) begin
          rvalid = 1; rdata = s_mem[s_araddr[5:2]]; rresp = resp_of(s_araddr); r_pend = 0;
        end else r_cnt--;
      end
      if (awvalid) begin
        if (aw_cnt == 0 && rnd) aw_dly = $urandom_range(0, 3);
        awready = (aw_cnt >= aw_dly); aw_cnt++;
      end else begin awready = 0; aw_cnt = 0; end
      if (wvalid) begin
        if (w_cnt == 0 && rnd) w_dly = $urandom_range(0, 3);
        wready = (w_cnt >= w_dly); w_cnt++;
      end else begin wready = 0; w_cnt = 0; end
      if (arvalid) begin
        if (ar_cnt == 0 && rnd) ar_dly = $urandom_range(0, 3);
        arready = (ar_cnt >= ar_dly); ar_cnt++;
      end else begin arready = 0; ar_cnt = 0; end
    end
  end

  // Response consumer.
  initial begin
    rsp_ready = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rsp_hold > 0) begin
        rsp_ready = 0;
        if (rsp_valid) rsp_hold--;
      end else if (rsp_rnd) rsp_ready = 1'($urandom);
      else rsp_ready = 1;
    end
  end

  // Monitor: traces, scoreboard pops and channel stability rules.
  initial begin
    exp_t e;
    bit rsp_stall, aw_stall, w_stall, ar_stall;
    logic [DW-1:0] p_rdata, p_wdata;
    logic [1:0]    p_resp;
    logic          p_write;
    logic [AW-1:0] p_awaddr, p_araddr;
    logic [SW-1:0] p_wstrb;
    rsp_stall = 0; aw_stall = 0; w_stall = 0; ar_stall = 0;
    forever begin
      @(negedge clk);
      if (cyc < TRN) begin
        tr_awv[cyc] = awvalid; tr_wv[cyc] = wvalid; tr_bready[cyc] = bready;
        tr_arv[cyc] = arvalid; tr_rready[cyc] = rready; tr_rspv[cyc] = rsp_valid;
      end
      if (rsp_stall) begin
        chk("rsp_valid_held", rsp_valid, 1);
        chk("rsp_rdata_held", rsp_rdata, p_rdata);
        chk("rsp_resp_held", rsp_resp, p_resp);
        chk("rsp_write_held", rsp_write, p_write);
      end
      if (aw_stall) begin
        chk("awvalid_held", awvalid, 1);
        chk("awaddr_stable", awaddr, p_awaddr);
      end
      if (w_stall) begin
        chk("wvalid_held", wvalid, 1);
        chk("wdata_stable", wdata, p_wdata);
        chk("wstrb_stable", wstrb, p_wstrb);
      end
      if (ar_stall) begin
        chk("arvalid_held", arvalid, 1);
        chk("araddr_stable", araddr, p_araddr);
      end
      if (bready) chk("bready_exclusive", awvalid | wvalid | arvalid | rready, 0);
      if (rready) chk("rready_exclusive", arvalid | awvalid | wvalid, 0);
      if (rsp_valid) chk("cmd_ready_in_rsp", cmd_ready, 0);
      if (rsp_valid && rsp_ready && !rst) begin
        last_hs = cyc;
        if (expq.size() == 0) chk("rsp_unexpected", 1, 0);
        else begin
          e = expq.pop_front();
          chk("rsp_write", rsp_write, e.w);
          chk("rsp_rdata", rsp_rdata, e.d);
          chk("rsp_resp", rsp_resp, e.r);
        end
      end
      rsp_stall = rsp_valid && !rsp_ready && !rst;
      aw_stall  = awvalid && !awready && !rst;
      w_stall   = wvalid && !wready && !rst;
      ar_stall  = arvalid && !arready && !rst;
      p_rdata = rsp_rdata; p_resp = rsp_resp; p_write = rsp_write;
      p_awaddr = awaddr; p_wdata = wdata; p_wstrb = wstrb; p_araddr = araddr;
    end
  end

  task automatic do_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [SW-1:0] s, output int acc);
    exp_t e;
    e.w = w;
    e.r = resp_of(a);
    if (w) begin
      for (int b = 0; b < SW; b++)
        if (s[b]) ref_mem[a[5:2]][8*b +: 8] = d[8*b +: 8];
      e.d = '0;
    end else e.d = ref_mem[a[5:2]];
    expq.push_back(e);
    addrq.push_back(a);
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    acc = -1;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (cmd_ready) begin acc = cyc; break; end
    end
    if (acc < 0) chk("cmd_accept_timeout", 1, 0);
    @(posedge clk);
    #1;
    cmd_valid = 0; cmd_write = 1'($urandom); cmd_addr = $urandom;
    cmd_wdata = $urandom; cmd_wstrb = SW'($urandom);
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 0;
    for (int t = 0; t < 400; t++) begin
      if (expq.size() == 0) begin done = 1; break; end
      @(negedge clk);
    end
    if (!done) chk(name, expq.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_awvalid"}, awvalid, 0);
    chk({tag, "_wvalid"}, wvalid, 0);
    chk({tag, "_bready"}, bready, 0);
    chk({tag, "_arvalid"}, arvalid, 0);
    chk({tag, "_rready"}, rready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
  endtask

  task automatic reset_when(input bit in_wb, input string tag);
    bit seen;
    seen = 0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_wb ? bready : rready) begin seen = 1; break; end
    end
    chk({tag, "_reached"}, seen, 1);
    @(posedge clk); #1; rst = 1;
    @(posedge clk); #1;
    check_idle(tag);
    rst = 0;
    expq.delete();
    addrq.delete();
  endtask

  initial begin
    int c0, c1, c2, c3, c4, h;
    rst = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    chk("reset_rsp_rdata", rsp_rdata, 0);
    chk("reset_rsp_resp", rsp_resp, 0);
    chk("reset_rsp_write", rsp_write, 0);
    chk("reset_awaddr", awaddr, 0);
    chk("reset_araddr", araddr, 0);
    chk("reset_wdata", wdata, 0);
    chk("reset_wstrb", wstrb, 0);
    chk("awprot", awprot, 0);
    chk("arprot", arprot, 0);
    rst = 0;
    @(posedge clk); #1;

    // Always-ready write, then back-to-back command at minimum spacing.
    do_cmd(1, 32'h0000_0004, 32'hDEAD_BEEF, 4'hF, c0);
    do_cmd(1, 32'h0000_0010, 32'h1234_5678, 4'hF, c1);
    wait_idle("wr_fast_idle");
    chk("wr_awvalid_c1", tr_awv[c0+1], 1);
    chk("wr_awvalid_c2", tr_awv[c0+2], 0);
    chk("wr_wvalid_c1", tr_wv[c0+1], 1);
    chk("wr_wvalid_c2", tr_wv[c0+2], 0);
    chk("wr_bready_c2", tr_bready[c0+2], 1);
    chk("wr_rspv_c2", tr_rspv[c0+2], 0);
    chk("wr_rspv_c3", tr_rspv[c0+3], 1);
    chk("cmd_spacing", c1 - c0, 4);

    // Read with ARREADY one cycle late and RVALID a few cycles later.
    ar_dly = 1; r_dly = 2;
    do_cmd(0, 32'h0000_0010, 32'h0, 4'h0, c2);
    wait_idle("rd_idle");
    chk("rd_arvalid_c2", tr_arv[c2+2], 1);
    chk("rd_arvalid_c3", tr_arv[c2+3], 0);
    chk("rd_rready_c2", tr_rready[c2+2], 0);
    chk("rd_rready_c5", tr_rready[c2+5], 1);
    chk("rd_rready_c6", tr_rready[c2+6], 0);
    chk("rd_rspv_c6", tr_rspv[c2+6], 1);
    ar_dly = 0; r_dly = 0;

    // Split write: AW immediately, W three cycles later.
    w_dly = 3;
    do_cmd(1, 32'h0000_0014, 32'hA5A5_0F0F, 4'h5, c3);
    wait_idle("split_idle");
    chk("split_awvalid_c2", tr_awv[c3+2], 0);
    chk("split_wvalid_c4", tr_wv[c3+4], 1);
    chk("split_wvalid_c5", tr_wv[c3+5], 0);
    chk("split_bready_c4", tr_bready[c3+4], 0);
    chk("split_bready_c5", tr_bready[c3+5], 1);

    // Reverse order plus a stray BVALID pulse while still in the write phase.
    w_dly = 0; aw_dly = 3; b_dly = 2; spur_en = 1; spur_done = 0;
    do_cmd(1, 32'h0000_0008, 32'h0BAD_F00D, 4'hF, c4);
    wait_idle("rev_idle");
    chk("rev_wvalid_c2", tr_wv[c4+2], 0);
    chk("rev_awvalid_c4", tr_awv[c4+4], 1);
    chk("rev_bready_c4", tr_bready[c4+4], 0);
    chk("rev_bready_c5", tr_bready[c4+5], 1);
    spur_en = 0; aw_dly = 0; b_dly = 0;

    // Backpressure on an error response, then the next command right behind it.
    rsp_hold = 5;
    do_cmd(0, 32'h0000_0080, 32'h0, 4'h0, c0);
    do_cmd(1, 32'h0000_00C4, 32'h5555_AAAA, 4'hC, c1);
    h = last_hs;
    chk("accept_after_rsp", c1, h + 1);
    chk("rsp_held_5", tr_rspv[h-5], 1);
    wait_idle("bp_idle");

    // Reset in WB and in RD, then a normal write/read.
    b_dly = 6;
    do_cmd(1, 32'h0000_0020, 32'hCAFE_0001, 4'hF, c0);
    reset_when(1, "rst_wb");
    b_dly = 0; r_dly = 6;
    do_cmd(0, 32'h0000_0020, 32'h0, 4'h0, c0);
    reset_when(0, "rst_rd");
    r_dly = 0;
    @(posedge clk); #1;
    do_cmd(1, 32'h0000_0028, 32'h1357_9BDF, 4'hF, c0);
    do_cmd(0, 32'h0000_0028, 32'h0, 4'h0, c1);
    do_cmd(0, 32'h0000_0020, 32'h0, 4'h0, c1);
    wait_idle("post_rst_idle");

    // Randomized traffic.
    rnd = 1; rsp_rnd = 1;
    for (int n = 0; n < 150; n++) begin
      logic [AW-1:0] a;
      a = $urandom & 32'hFFFF_F0FC;
      do_cmd(1'($urandom), a, $urandom, SW'($urandom), c0);
    end
    wait_idle("random_idle");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axi_lite_master.md
Name: axi_lite_master

Overview:
- Single-outstanding AXI4-Lite master. Converts a simple command/response handshake into AXI4-Lite read and write transactions.
- Lets on-chip control logic (coefficient loader, adaptation engine, test sequencers) program and read back AXI4-Lite register slaves such as the FIR control register bank, without a processor.
- Sits between the internal command source and the AXI4-Lite interconnect / slave port.

Parameters:
- C_M_AXI_DATA_WIDTH, 32, AXI data width in bits (32 or 64).
- C_M_AXI_ADDR_WIDTH, 32, AXI address width in bits.

Ports:
- M_AXI_ACLK  in  1  single clock; all logic on rising edge.
- M_AXI_ARESET  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  master accepts command.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  C_M_AXI_ADDR_WIDTH  byte address, passed unaltered.
- cmd_wdata  in  C_M_AXI_DATA_WIDTH  write data.
- cmd_wstrb  in  C_M_AXI_DATA_WIDTH/8  byte strobes.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_write  out  1  response belongs to a write.
- rsp_rdata  out  C_M_AXI_DATA_WIDTH  read data; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP as received.
- M_AXI_AWADDR, M_AXI_AWPROT(3), M_AXI_AWVALID  out;  M_AXI_AWREADY  in.
- M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID  out;  M_AXI_WREADY  in.
- M_AXI_BRESP(2), M_AXI_BVALID  in;  M_AXI_BREADY  out.
- M_AXI_ARADDR, M_AXI_ARPROT(3), M_AXI_ARVALID  out;  M_AXI_ARREADY  in.
- M_AXI_RDATA, M_AXI_RRESP(2), M_AXI_RVALID  in;  M_AXI_RREADY  out.

Behaviour:
- Reset (sampled at edge with M_AXI_ARESET=1): state IDLE; all VALID/READY outputs 0; rsp_valid 0; rsp_rdata, rsp_resp, rsp_write, address and data registers 0.
- Reset mid-transaction aborts the transaction with no response. Slave recovery is the system reset's job.
- AWPROT and ARPROT are constant 3'b000.
- All AXI outputs are registered. cmd_ready is combinational: it is 1 iff state==IDLE.
- IDLE: on cmd_valid&&cmd_ready, latch addr/wdata/wstrb/write.
  - Write: go to WR. AWVALID=WVALID=1 from the next cycle. Clear aw_done and w_done.
  - Read: go to RA. ARVALID=1 from the next cycle.
- WR: AW and W channels complete independently.
  - On AWVALID&&AWREADY: set aw_done; drop AWVALID next cycle.
  - On WVALID&&WREADY: set w_done; drop WVALID next cycle.
  - Handshakes may occur in the same cycle or in either order.
  - When both are done (counting the current cycle): go to WB with BREADY=1.
  - AWADDR/WDATA/WSTRB are held stable while their VALID is high. VALID is never withdrawn before READY.
- WB: BREADY=1. On BVALID: capture BRESP, rsp_write=1, rsp_rdata=0, BREADY=0, go to RSP.
- RA: hold ARVALID/ARADDR until ARREADY. On handshake: ARVALID=0, RREADY=1, go to RD.
- RD: RREADY=1. On RVALID: capture RDATA/RRESP, rsp_write=0, RREADY=0, go to RSP.
- RSP: rsp_valid=1, with rsp_* held stable, until rsp_ready. On handshake go to IDLE. The next command is accepted no earlier than the following cycle.
- BREADY is 0 outside WB; RREADY is 0 outside RD. A BVALID/RVALID seen in other states is ignored (not acknowledged).
- Error responses (SLVERR/DECERR) are reported verbatim. No retry.
- No timeout. A slave that never responds stalls the master indefinitely.
- Latency with always-ready slave, command accepted at cycle 0:
  - AW/W (or AR) VALID high in cycle 1.
  - BREADY (or RREADY) high in cycle 2.
  - If B/R VALID is already high in cycle 2, rsp_valid rises in cycle 3.
  - Minimum command-to-command spacing is 4 cycles.

Test Plan:
- Write 0x0000_0004 data 0xDEAD_BEEF strb 0xF to always-ready slave; BVALID in cycle 2 -> AW/W VALID high cycle 1 only; rsp_valid cycle 3, rsp_write=1, rsp_resp=00, rsp_rdata=0.
- Read 0x0000_0010 from a slave returning 0x1234_5678 with RVALID 3 cycles after AR -> ARVALID held until ARREADY; RREADY held until RVALID; rsp_rdata=0x1234_5678, rsp_resp=00.
- Split write: AWREADY in cycle 1, WREADY in cycle 4 -> AWVALID drops cycle 2, WVALID stays 1 with stable WDATA through cycle 4; BREADY first high cycle 5.
- Reverse order: WREADY before AWREADY, and a BVALID pulse injected during WR -> BREADY stays 0 in WR; the response is taken only in WB.
- Backpressure and errors: rsp_ready low 5 cycles with RRESP=2'b10 -> rsp_valid/rsp_resp=10 held stable; cmd_ready 0 throughout; command accepted in the cycle after the handshake.
- Reset asserted in WB and again in RD -> next edge all VALID/READY=0, rsp_valid=0, cmd_ready=1; a subsequent write completes normally.
